// File: rtl/rmem_pkg.sv
// Shared AXI read-side constants, state encoding and small helpers for the
// rmem burst reader.
package rmem_pkg;

    localparam logic [2:0] SIZE_32B         = 3'b101;
    localparam logic [1:0] BURST_INCR       = 2'b01;
    localparam logic [3:0] CACHE_MODIFIABLE = 4'b0011;
    localparam logic [2:0] PROT_NONE        = 3'b000;
    localparam int         PAGE_BYTES       = 4096;
    localparam int         BEAT_BYTES       = 32;
    localparam int         PAGE_BEATS       = PAGE_BYTES / BEAT_BYTES;
    localparam int         PG_IDX_W         = 7;
    localparam int         LEN_W            = 9;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } rd_state_t;

    function automatic logic [LEN_W-1:0] min_len(input logic [LEN_W-1:0] a,
                                                 input logic [LEN_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/rmem_burst_len.sv
// Beats for the next AR burst: bounded by what is left, the max burst size
// and the distance to the next 4 KB page.
module rmem_burst_len
    import rmem_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic [31:0]         i_remaining,
    input  logic [PG_IDX_W-1:0] i_page_beat,
    output logic [LEN_W-1:0]    o_len
);

    logic [LEN_W-1:0] w_page_left;
    logic [LEN_W-1:0] w_rem_cap;

    // Start address is beat aligned, so the page index is addr[11:5].
    assign w_page_left = LEN_W'(PAGE_BEATS) - {{(LEN_W-PG_IDX_W){1'b0}}, i_page_beat};
    assign w_rem_cap   = (i_remaining > 32'(MAX_BURST)) ? LEN_W'(MAX_BURST)
                                                        : i_remaining[LEN_W-1:0];
    assign o_len       = min_len(w_rem_cap, w_page_left);

endmodule

// File: rtl/rmem_burst_reader.sv
// Issues page-safe INCR read bursts for a command and forwards the R channel
// straight onto an AXI-stream with a beat-count based TLAST.
module rmem_burst_reader
    import rmem_pkg::*;
#(
    parameter int ADDR_W          = 64,
    parameter int DATA_W          = 256,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_beats,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              m_axi_rmem0_ARVALID,
    input  logic              m_axi_rmem0_ARREADY,
    output logic [ADDR_W-1:0] m_axi_rmem0_ARADDR,
    output logic [7:0]        m_axi_rmem0_ARLEN,
    output logic [2:0]        m_axi_rmem0_ARSIZE,
    output logic [1:0]        m_axi_rmem0_ARBURST,
    output logic              m_axi_rmem0_ARID,
    output logic [3:0]        m_axi_rmem0_ARCACHE,
    output logic [2:0]        m_axi_rmem0_ARPROT,
    input  logic              m_axi_rmem0_RVALID,
    output logic              m_axi_rmem0_RREADY,
    input  logic [DATA_W-1:0] m_axi_rmem0_RDATA,
    input  logic [1:0]        m_axi_rmem0_RRESP,
    input  logic              m_axi_rmem0_RLAST,
    input  logic              m_axi_rmem0_RID,
    output logic              out_TVALID,
    input  logic              out_TREADY,
    output logic [DATA_W-1:0] out_TDATA,
    output logic              out_TLAST
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    rd_state_t         r_state;
    rd_state_t         w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_remaining;
    logic [31:0]       r_total;
    logic [31:0]       r_beat_cnt;
    logic [OUT_W-1:0]  r_outstanding;
    logic              r_err;

    logic [LEN_W-1:0]  w_len;
    logic [31:0]       w_rem_after;
    logic              w_cmd_hs;
    logic              w_ar_hs;
    logic              w_r_hs;
    logic              w_rlast_hs;
    logic              w_all_beats;
    logic              w_unused;

    rmem_burst_len #(
        .MAX_BURST   (MAX_BURST)
    ) u_burst_len (
        .i_remaining (r_remaining),
        .i_page_beat (r_addr[11:5]),
        .o_len       (w_len)
    );

    assign w_cmd_hs    = cmd_valid & cmd_ready;
    assign w_ar_hs     = m_axi_rmem0_ARVALID & m_axi_rmem0_ARREADY;
    assign w_r_hs      = m_axi_rmem0_RVALID & m_axi_rmem0_RREADY;
    assign w_rlast_hs  = w_r_hs & m_axi_rmem0_RLAST;
    assign w_rem_after = r_remaining - {{(32-LEN_W){1'b0}}, w_len};
    assign w_all_beats = (r_beat_cnt == r_total);
    assign w_unused    = ^{m_axi_rmem0_RID, cmd_addr[4:0]};

    assign m_axi_rmem0_ARADDR  = r_addr;
    assign m_axi_rmem0_ARLEN   = w_len[7:0] - 8'd1;
    assign m_axi_rmem0_ARSIZE  = SIZE_32B;
    assign m_axi_rmem0_ARBURST = BURST_INCR;
    assign m_axi_rmem0_ARID    = 1'b0;
    assign m_axi_rmem0_ARCACHE = CACHE_MODIFIABLE;
    assign m_axi_rmem0_ARPROT  = PROT_NONE;

    // R is a wire-through to the stream; backpressure comes from downstream.
    assign m_axi_rmem0_RREADY = out_TREADY & busy;
    assign out_TVALID         = m_axi_rmem0_RVALID & busy;
    assign out_TDATA          = m_axi_rmem0_RDATA;
    assign out_TLAST          = busy & ((r_beat_cnt + 32'd1) == r_total);
    assign err                = r_err;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt         = r_state;
        cmd_ready           = 1'b0;
        busy                = 1'b1;
        done                = 1'b0;
        m_axi_rmem0_ARVALID = 1'b0;
        case (r_state)
            IDLE: begin
                busy      = 1'b0;
                cmd_ready = ~ap_rst;
                if (w_cmd_hs) w_state_nxt = (cmd_beats == 32'd0) ? DONE : ISSUE;
            end
            ISSUE: begin
                // Outstanding cannot grow while ARVALID waits, so it stays up.
                m_axi_rmem0_ARVALID = ~ap_rst & (r_outstanding < OUT_W'(MAX_OUTSTANDING));
                if (w_ar_hs && w_rem_after == 32'd0) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (r_outstanding == '0 && w_all_beats) w_state_nxt = DONE;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_addr        <= '0;
            r_remaining   <= '0;
            r_total       <= '0;
            r_beat_cnt    <= '0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            if (w_cmd_hs) begin
                r_addr      <= {cmd_addr[ADDR_W-1:5], 5'b0};
                r_remaining <= cmd_beats;
                r_total     <= cmd_beats;
                r_beat_cnt  <= '0;
                r_err       <= 1'b0;
            end else begin
                if (w_ar_hs) begin
                    r_addr      <= r_addr + ADDR_W'({w_len, 5'b0});
                    r_remaining <= w_rem_after;
                end
                if (w_r_hs) r_beat_cnt <= r_beat_cnt + 32'd1;
                if (w_r_hs && m_axi_rmem0_RRESP != 2'b00) r_err <= 1'b1;
            end
            case ({w_ar_hs, w_rlast_hs})
                2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

endmodule

// File: doc/rmem_burst_reader.md
RMEM_BURST_READER -- requirements
Module: rmem_burst_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, AXI byte-address width.
REQ-002 SHALL have parameter DATA_W, default 256, AXI/stream data width (32 B/beat).
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum beats per AR burst.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, maximum AR bursts in flight.
REQ-005 SHALL have port ap_clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port ap_rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
REQ-008 SHALL have port cmd_addr  in  ADDR_W  start byte address.
REQ-009 SHALL have port cmd_beats  in  32  transfer length in beats.
REQ-010 SHALL have ports busy / done / err  out  1 each  status: busy = not IDLE, done = 1-cycle completion pulse, err = sticky bad response.
REQ-011 SHALL have ports m_axi_rmem0_ARVALID out 1, ARREADY in 1, ARADDR out ADDR_W, ARLEN out 8, ARSIZE out 3, ARBURST out 2, ARID out 1, ARCACHE out 4, ARPROT out 3.
REQ-012 SHALL have ports m_axi_rmem0_RVALID in 1, RREADY out 1, RDATA in DATA_W, RRESP in 2, RLAST in 1, RID in 1.
REQ-013 SHALL have ports out_TVALID out 1, out_TREADY in 1, out_TDATA out DATA_W, out_TLAST out 1: downstream stream to the vadd compute/write stage.

Function
REQ-014 SHALL implement states IDLE, ISSUE, DRAIN, DONE; cmd_ready = 1 only in IDLE and not in reset.
REQ-015 SHALL, on cmd handshake, latch addr with low 5 bits forced to 0, latch remaining = cmd_beats, clear err, go to ISSUE; with cmd_beats = 0 go directly to DONE, issuing no AR.
REQ-016 SHALL compute burst length = min(remaining, MAX_BURST, (4096 - addr[11:0])/32), never crossing a 4 KB boundary.
REQ-017 SHALL drive ARLEN = length-1, ARSIZE = 3'b101, ARBURST = 2'b01, ARID = 0, ARCACHE = 4'b0011, ARPROT = 0.
REQ-018 SHALL assert ARVALID in ISSUE only while outstanding < MAX_OUTSTANDING, and SHALL hold ARVALID and all AR fields stable until ARREADY.
REQ-019 SHALL, on AR handshake, advance addr by length*32, decrement remaining by length, increment outstanding; when remaining reaches 0 go to DRAIN.
REQ-020 SHALL decrement outstanding on R handshake with RLAST; simultaneous AR handshake and RLAST handshake SHALL leave outstanding unchanged.
REQ-021 SHALL pass R to stream combinationally: out_TVALID = RVALID & busy, out_TDATA = RDATA, RREADY = out_TREADY & busy (zero added latency).
REQ-022 SHALL count delivered beats and assert out_TLAST on the beat numbered cmd_beats, independent of RLAST.
REQ-023 SHALL set err when any R handshake has RRESP != 0; data SHALL still be forwarded; err held until next command accept.
REQ-024 SHALL leave DRAIN for DONE when outstanding = 0 and all beats delivered; DONE lasts one cycle with done = 1, then IDLE.

Reset
REQ-025 SHALL, with ap_rst high at a clock edge, force state IDLE, outstanding/remaining/beat counters 0, err 0, and drive ARVALID, RREADY, out_TVALID, done, busy, cmd_ready all 0.
REQ-026 SHALL abandon any transfer on reset mid-operation with no further AR issued; reset SHALL be asserted together with the interconnect reset.

Structure
REQ-027 SHALL take AXI constants (SIZE_32B, BURST_INCR, CACHE_MODIFIABLE, PAGE_BYTES=4096) and the state enum from shared package rmem_pkg.
REQ-028 SHALL place the burst-length computation of REQ-016 in a combinational sub-module rmem_burst_len.

Verification
REQ-029 Bench SHALL cover addr 0x1000, beats 40, ARREADY always 1 -> ARLEN 15,15,7 at 0x1000,0x1200,0x1400; 40 beats out; TLAST on beat 40; one done pulse.
REQ-030 Bench SHALL cover addr 0x1FC0, beats 8 -> ARLEN 1 at 0x1FC0 then ARLEN 5 at 0x2000 (4 KB split).
REQ-031 Bench SHALL cover R withheld, beats 128 -> exactly 4 ARs issued, fifth ARVALID only after first RLAST handshake.
REQ-032 Bench SHALL cover out_TREADY toggling randomly 50% -> RREADY mirrors it, no beat lost or duplicated, data order preserved.
REQ-033 Bench SHALL cover RRESP = 2'b10 on beat 3 of 16 -> err = 1 through done, all 16 beats delivered, err cleared on next cmd accept; plus cmd_beats = 0 -> no AR, done 1 cycle later.
REQ-034 Bench SHALL cover ap_rst asserted mid-ISSUE -> next cycle all outputs per REQ-025, cmd_ready = 1 the cycle after release.
